// File: rtl/fifo_pkg.sv
// Shared async-FIFO constants and the read-side prefetch buffer state type.
package fifo_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int PTR_W  = ADDR_W + 1;

    // Occupancy of the 2-entry read prefetch buffer; encoding equals the count.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/rd_prefetch_buf.sv
// Two-entry ordered register buffer: head in ent0, write behind live entries,
// shift on pop, flush empties the buffer without touching the data registers.
module rd_prefetch_buf
    import fifo_pkg::*;
#(
    parameter int DATA_W = fifo_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              wr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [1:0]        cnt_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] head_o
);

    buf_state_e        state_q;
    logic [DATA_W-1:0] ent0_q;
    logic [DATA_W-1:0] ent1_q;

    // Occupancy FSM and entry storage; a same-edge shift and write keeps order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
            ent0_q  <= '0;
            ent1_q  <= '0;
        end else if (flush_i) begin
            state_q <= BUF_EMPTY;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (wr_i) begin
                        ent0_q  <= wdata_i;
                        state_q <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    case ({wr_i, pop_i})
                        2'b10: begin
                            ent1_q  <= wdata_i;
                            state_q <= BUF_FULL;
                        end
                        2'b01:   state_q <= BUF_EMPTY;
                        2'b11:   ent0_q  <= wdata_i;
                        default: ;
                    endcase
                end
                BUF_FULL: begin
                    // A write without a pop cannot happen: the credit check forbids it.
                    case ({wr_i, pop_i})
                        2'b01: begin
                            ent0_q  <= ent1_q;
                            state_q <= BUF_ONE;
                        end
                        2'b11: begin
                            ent0_q <= ent1_q;
                            ent1_q <= wdata_i;
                        end
                        default: ;
                    endcase
                end
                default: state_q <= BUF_EMPTY;
            endcase
        end
    end

    assign cnt_o   = state_q;
    assign valid_o = (state_q != BUF_EMPTY);
    assign head_o  = ent0_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side output stage of the async FIFO: issues credit-limited pops, tracks
// the one-cycle memory latency and streams words out of a 2-entry buffer.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_W = fifo_pkg::DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              empty,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              flush,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  words_out
);

    logic             inflight_q;
    logic             pop;
    logic             fire;
    logic [1:0]       cnt;
    logic [2:0]       credit_use;
    logic [CNT_W-1:0] words_q;
    logic [CNT_W-1:0] words_d;

    // A flush cycle never counts as an accept, even with m_ready high.
    assign fire = m_valid & m_ready & ~flush;

    // Slots committed after this edge: buffered + arriving - leaving; must stay below 2
    // for a new pop so the word it produces always has a slot.
    assign credit_use = {1'b0, cnt} + {2'b00, inflight_q} - {2'b00, fire};
    assign rd_en      = rd_rst & ~empty & ~flush & (credit_use < 3'd2);
    assign pop        = rd_en & ~empty;

    // rd_data is valid the cycle after a pop; flush abandons the word in flight.
    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) inflight_q <= 1'b0;
        else         inflight_q <= pop & ~flush;
    end

    assign words_d = fire ? words_q + CNT_W'(1) : words_q;

    // Accepted-word counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) words_q <= '0;
        else         words_q <= words_d;
    end

    rd_prefetch_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk     (rd_clk),
        .rst_n   (rd_rst),
        .flush_i (flush),
        .wr_i    (inflight_q),
        .wdata_i (rd_data),
        .pop_i   (fire),
        .cnt_o   (cnt),
        .valid_o (m_valid),
        .head_o  (m_data)
    );

    assign words_out = words_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

    localparam int DW = 8;

    logic          rd_clk;
    logic          rd_rst;
    logic          empty;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          flush;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic [15:0]   words_out;

    logic          rd_en4;
    logic          m_valid4;
    logic [DW-1:0] m_data4;
    logic [3:0]    words_out4;

    int tests;
    int fails;
    int pops_total;
    int fires_total;

    logic [DW-1:0] mem_q[$];
    logic [DW-1:0] exp_q[$];
    logic          mm_pop;
    logic [DW-1:0] sb_exp;

    fifo_rd_stream #(.DATA_W(DW), .CNT_W(16)) u_dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .empty(empty), .rd_en(rd_en),
        .rd_data(rd_data), .flush(flush), .m_valid(m_valid), .m_data(m_data),
        .m_ready(m_ready), .words_out(words_out)
    );

    // Narrow-counter copy on the same inputs; its pops match the main instance.
    fifo_rd_stream #(.DATA_W(DW), .CNT_W(4)) u_dut4 (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .empty(empty), .rd_en(rd_en4),
        .rd_data(rd_data), .flush(flush), .m_valid(m_valid4), .m_data(m_data4),
        .m_ready(m_ready), .words_out(words_out4)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    // FIFO memory + pointer model: pop on rd_en & !empty, data next cycle, registered empty.
    always @(posedge rd_clk) begin
        mm_pop = rd_en && !empty;
        #1;
        if (mm_pop && mem_q.size() > 0) begin
            rd_data = mem_q.pop_front();
            pops_total++;
        end else begin
            rd_data = 8'hEE;
        end
        empty = (mem_q.size() == 0);
    end

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge rd_clk) begin
        if (rd_rst) begin
            tests++;
            if (empty && rd_en) begin
                fails++;
                $display("FAIL rd_en_while_empty: rd_en=%0b empty=%0b expected rd_en=0", rd_en, empty);
            end
            if (m_valid && m_ready && !flush) begin
                tests++;
                fires_total++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: got %0h, expected no word", m_data);
                end else begin
                    sb_exp = exp_q.pop_front();
                    if (m_data !== sb_exp) begin
                        fails++;
                        $display("FAIL sb_data: got %0h expected %0h", m_data, sb_exp);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic push_word(input logic [DW-1:0] w);
        mem_q.push_back(w);
        exp_q.push_back(w);
        empty = 1'b0;
    endtask

    task automatic wait_drain(output logic timed_out);
        for (int i = 0; i < 60 && (exp_q.size() != 0 || m_valid); i++) @(posedge rd_clk);
        #2;
        timed_out = (exp_q.size() != 0) || m_valid;
    endtask

    task automatic test_reset();
        rd_rst = 1'b0; empty = 1'b1; flush = 1'b0; m_ready = 1'b0;
        for (int i = 1; i <= 16; i++) push_word(DW'(i));
        repeat (3) @(posedge rd_clk);
        @(negedge rd_clk);
        tests++; if (rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en: got %0b expected 0", rd_en); end
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid: got %0b expected 0", m_valid); end
        tests++; if (words_out !== 16'd0) begin fails++; $display("FAIL reset_words_out: got %0d expected 0", words_out); end
        tests++; if (m_data !== 8'h00) begin fails++; $display("FAIL reset_m_data: got %0h expected 0", m_data); end
        @(posedge rd_clk); #2;
        rd_rst = 1'b1; m_ready = 1'b1;
        @(negedge rd_clk);
        tests++; if (rd_en !== 1'b1) begin fails++; $display("FAIL release_rd_en: got %0b expected 1", rd_en); end
    endtask

    task automatic test_streaming();
        @(posedge rd_clk);
        @(negedge rd_clk);
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL stream_latency: m_valid=%0b one edge after pop, expected 0", m_valid); end
        for (int i = 0; i < 16; i++) begin
            @(negedge rd_clk);
            tests++;
            if (m_valid !== 1'b1) begin fails++; $display("FAIL stream_gap: cycle %0d m_valid=%0b expected 1", i, m_valid); end
        end
        @(posedge rd_clk); #2;
        tests++; if (words_out !== 16'd16) begin fails++; $display("FAIL stream_words_out: got %0d expected 16", words_out); end
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL stream_end_valid: got %0b expected 0", m_valid); end
        tests++; if (words_out4 !== 4'd0) begin fails++; $display("FAIL stream_wrap4: got %0d expected 0", words_out4); end
    endtask

    task automatic test_backpressure();
        int   p0;
        logic to;
        m_ready = 1'b0;
        p0 = pops_total;
        for (int i = 1; i <= 8; i++) push_word(DW'(i));
        repeat (10) @(posedge rd_clk);
        @(negedge rd_clk);
        tests++; if (pops_total - p0 != 2) begin fails++; $display("FAIL bp_pops: got %0d expected 2", pops_total - p0); end
        tests++; if (rd_en !== 1'b0) begin fails++; $display("FAIL bp_rd_en: got %0b expected 0", rd_en); end
        tests++; if (u_dut.cnt !== 2'd2) begin fails++; $display("FAIL bp_cnt: got %0d expected 2", u_dut.cnt); end
        tests++; if (m_valid !== 1'b1 || m_data !== 8'h01) begin fails++; $display("FAIL bp_hold: valid=%0b data=%0h expected 1/01", m_valid, m_data); end
        @(posedge rd_clk); #2;
        m_ready = 1'b1;
        wait_drain(to);
        tests++; if (to) begin fails++; $display("FAIL bp_drain_timeout: %0d words left, expected 0", exp_q.size()); end
        tests++; if (words_out !== 16'd24) begin fails++; $display("FAIL bp_words_out: got %0d expected 24", words_out); end
    endtask

    task automatic test_empty_boundary();
        int p0;
        int vcnt;
        p0 = pops_total; vcnt = 0;
        push_word(8'hA5);
        for (int i = 0; i < 8; i++) begin
            @(negedge rd_clk);
            if (m_valid) vcnt++;
        end
        tests++; if (pops_total - p0 != 1) begin fails++; $display("FAIL empty_pops: got %0d expected 1", pops_total - p0); end
        tests++; if (vcnt != 1) begin fails++; $display("FAIL empty_valid_cycles: got %0d expected 1", vcnt); end
        tests++; if (words_out !== 16'd25) begin fails++; $display("FAIL empty_words_out: got %0d expected 25", words_out); end
        @(posedge rd_clk); #2;
    endtask

    task automatic test_flush();
        logic [15:0] wo0;
        logic        got;
        logic        to;
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(8'h11 + DW'(i));
        repeat (6) @(posedge rd_clk);
        #2 m_ready = 1'b1;
        @(posedge rd_clk); #2;
        flush = 1'b1;
        wo0 = words_out;
        @(negedge rd_clk);
        tests++; if (rd_en !== 1'b0) begin fails++; $display("FAIL flush_rd_en: got %0b expected 0", rd_en); end
        tests++; if (pops_total - fires_total != 2) begin fails++; $display("FAIL flush_outstanding: got %0d expected 2", pops_total - fires_total); end
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        @(posedge rd_clk); #2;
        flush = 1'b0;
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %0b expected 0", m_valid); end
        tests++; if (words_out !== wo0 || wo0 !== 16'd26) begin fails++; $display("FAIL flush_words_out: got %0d expected 26", words_out); end
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge rd_clk);
            got = m_valid;
        end
        tests++; if (!got || m_data !== 8'h14) begin fails++; $display("FAIL flush_next_word: valid=%0b data=%0h expected 1/14", got, m_data); end
        wait_drain(to);
        tests++; if (to) begin fails++; $display("FAIL flush_drain_timeout: %0d words left, expected 0", exp_q.size()); end
        tests++; if (words_out !== 16'd31) begin fails++; $display("FAIL flush_words_total: got %0d expected 31", words_out); end
    endtask

    task automatic test_wrap();
        logic to;
        m_ready = 1'b0;
        push_word(8'h31);
        push_word(8'h32);
        repeat (4) @(posedge rd_clk);
        @(negedge rd_clk);
        tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL midrst_pre_valid: got %0b expected 1", m_valid); end
        #1 rd_rst = 1'b0;
        #1;
        tests++; if (m_valid !== 1'b0 || m_data !== 8'h00) begin fails++; $display("FAIL midrst_clear: valid=%0b data=%0h expected 0/00", m_valid, m_data); end
        tests++; if (words_out !== 16'd0 || words_out4 !== 4'd0) begin fails++; $display("FAIL midrst_words: got %0d/%0d expected 0/0", words_out, words_out4); end
        mem_q.delete();
        exp_q.delete();
        empty = 1'b1;
        @(posedge rd_clk); #2;
        rd_rst = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 17; i++) push_word(8'h40 + DW'(i));
        wait_drain(to);
        tests++; if (to) begin fails++; $display("FAIL wrap_drain_timeout: %0d words left, expected 0", exp_q.size()); end
        tests++; if (words_out4 !== 4'd1) begin fails++; $display("FAIL wrap_words_out4: got %0d expected 1", words_out4); end
        tests++; if (words_out !== 16'd17) begin fails++; $display("FAIL wrap_words_out16: got %0d expected 17", words_out); end
    endtask

    initial begin
        tests = 0; fails = 0; pops_total = 0; fires_total = 0;
        rd_data = 8'hEE;
        test_reset();
        test_streaming();
        test_backpressure();
        test_empty_boundary();
        test_flush();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
